awp_loopcnt: RTL and testbench
==============================

# awp_loopcnt

Parametrised multi-channel loop counter bank for the AWP arithmetic unit. It is the successor to the single 6-bit FIC counter. It provides CHANNELS independent up/down counters of WIDTH bits, each with parallel load and synchronous clear. It also generates a per-channel nonzero flag and registered loop-end and wrap strobes, so AWP microcode can run nested shift/iteration loops without reloading a shared counter. The block sits between the AWP control sequencer, which drives the strobes, and the AWP condition logic, which consumes `fic`, `nz` and `tc`.

## Interface
- WIDTH, 6: counter width in bits (≥2)
- CHANNELS, 2: number of independent counters (1..8)
- SELW, $clog2(CHANNELS) min 1: width of the channel select
- clk_sys  in  1  system clock; all state changes on rising edge
- rab_n  in  1  reset; asynchronous, active-low
- sel  in  SELW  channel addressed by this cycle's strobes and by `cnt`/`fic`
- load  in  1  parallel load of `in` into the selected channel
- clr  in  1  synchronous clear of the selected channel
- cda  in  1  decrement the selected channel
- cua  in  1  increment the selected channel
- in  in  WIDTH  load value
- cnt  out  WIDTH  current value of the selected channel (combinational mux of registers)
- fic  out  1  selected channel nonzero (OR-reduce of `cnt`)
- nz  out  CHANNELS  per-channel nonzero flags, bit i = channel i
- tc  out  1  loop-end strobe: registered one-cycle pulse
- wrap  out  1  wrap strobe: registered one-cycle pulse

## Operation
- Only the channel addressed by `sel` changes. All other channels hold.
- Per-edge priority on the selected channel: clr > load > (cda/cua) > hold.
- If cda and cua are asserted together with no clr or load, the result is a net zero: the channel holds, and no tc or wrap is produced.
- Decrement is value−1 mod 2^WIDTH. Increment is value+1 mod 2^WIDTH. Load takes `in` verbatim.
- tc is set on the next edge when the selected channel goes 1→0 via cda alone. It is not set for clr, for load of 0, or for reset.
- wrap is set on the next edge when cda alone acts on 0 (wraps to all-ones), or cua alone acts on all-ones (wraps to 0).
- tc and wrap are cleared on every edge where their set condition is false, so they never last more than one cycle. A back-to-back qualifying strobe gives consecutive pulses.
- If `sel` ≥ CHANNELS (non-power-of-2 CHANNELS), all strobes are ignored, `cnt` reads 0, `fic` reads 0, and tc/wrap stay 0.

## Timing
- Reset (rab_n low, asynchronous) sets every channel to 0, nz to 0, tc to 0 and wrap to 0. Release is synchronous to clk_sys by the surrounding reset logic.
- Strobe-to-count latency is 1 edge. `cnt`, `fic` and `nz` reflect the new value directly after the edge, with zero added latency.
- tc and wrap are high for exactly the cycle after the edge that caused them.
- `sel` may change every cycle. `cnt`/`fic` follow `sel` combinationally in the same cycle.
- If reset is asserted mid-loop, it aborts immediately. A tc pending for the next edge is lost.

## Configuration
- AWP_LOOPCNT_SAT_EN defined:
  - cda at 0 holds at 0.
  - cua at all-ones holds at all-ones.
  - wrap is driven high for one cycle in place of the wrap event and reports a saturation attempt.
  - tc behaviour is unchanged.
- Undefined: modulo wrap-around as described in Operation.
- The macro is global. All channels use the same mode.

## Structure
- Shared package `awp_pkg`: default WIDTH/CHANNELS constants, and the channel-op encoding (HOLD, CLR, LOAD, DEC, INC) used by the decoder and the channel.
- Sub-module `awp_loopcnt_ch` holds one channel's register, the op decode result input, next-value and saturate/wrap logic, and its tc/wrap event terms. The top instantiates CHANNELS of these via generate, registers the OR of the selected tc and wrap events, and muxes `cnt`.

## Test plan
- Reset: WIDTH=6, CHANNELS=2, set ch0=5 then pull rab_n low mid-cycle → cnt=0, nz=00, tc=0 and wrap=0 immediately, without waiting for a clock edge.
- Loop: load ch1=3, then 3 cycles of cda on sel=1 → cnt goes 2,1,0; tc high only in the cycle after the third edge; nz[1] drops; ch0 unchanged.
- Wrap: ch0=0, cda → cnt=63 and wrap pulse for 1 cycle. With AWP_LOOPCNT_SAT_EN: cnt stays 0 and wrap pulses. The same check with cua at 63 gives 0 without the macro, and 63 held with it.
- Priority: with ch0=10, clr+load(in=7)+cda → 0; load(in=7)+cda → 7; cda+cua → 10 held, no tc or wrap.
- Interleave: alternate sel 0/1 each cycle with cda, starting from ch0=2 and ch1=1 → ch1 tc after the first ch1 edge, ch0 tc after its second edge, and per-channel values stay independent.
- Out of range: CHANNELS=3, sel=3 with load in=9 → no channel changes, cnt=0, fic=0.

Source files
------------

// File: rtl/awp_pkg.sv
// Shared constants and channel-op encoding for the AWP loop counter bank.
package awp_pkg;

  localparam int DEF_WIDTH    = 6;
  localparam int DEF_CHANNELS = 2;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_CLR,
    OP_LOAD,
    OP_DEC,
    OP_INC
  } ch_op_e;

  // A single channel still needs a one-bit select.
  function automatic int sel_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/awp_loopcnt_if.sv
// Strobe/status bundle between the AWP sequencer/condition logic and the loop counter bank.
interface awp_loopcnt_if import awp_pkg::*; #(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int SELW     = sel_width(CHANNELS)
);

  logic [SELW-1:0]     sel;
  logic                load;
  logic                clr;
  logic                cda;
  logic                cua;
  logic [WIDTH-1:0]    in;
  logic [WIDTH-1:0]    cnt;
  logic                fic;
  logic [CHANNELS-1:0] nz;
  logic                tc;
  logic                wrap;

  modport master (
    output sel, load, clr, cda, cua, in,
    input  cnt, fic, nz, tc, wrap
  );

  modport slave (
    input  sel, load, clr, cda, cua, in,
    output cnt, fic, nz, tc, wrap
  );

endinterface

// File: rtl/awp_loopcnt_ch.sv
// One loop-counter channel: value register, next-value logic and tc/wrap event terms.
// With AWP_LOOPCNT_SAT_EN the ends saturate (wrap event still raised) instead of wrapping.
module awp_loopcnt_ch import awp_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  ch_op_e           op_i,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] val_o,
  output logic             tc_ev_o,
  output logic             wrap_ev_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] val_q, val_d;

  always_comb begin
    val_d     = val_q;
    tc_ev_o   = 1'b0;
    wrap_ev_o = 1'b0;
    case (op_i)
      OP_CLR:  val_d = '0;
      OP_LOAD: val_d = in_i;
      OP_DEC: begin
        tc_ev_o   = (val_q == ONE);
        wrap_ev_o = (val_q == '0);
`ifdef AWP_LOOPCNT_SAT_EN
        if (val_q != '0) val_d = val_q - ONE;
`else
        val_d = val_q - ONE;
`endif
      end
      OP_INC: begin
        wrap_ev_o = (val_q == '1);
`ifdef AWP_LOOPCNT_SAT_EN
        if (val_q != '1) val_d = val_q + ONE;
`else
        val_d = val_q + ONE;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) val_q <= '0;
    else          val_q <= val_d;
  end

  assign val_o = val_q;

endmodule

// File: rtl/awp_loopcnt.sv
// AWP loop counter bank: CHANNELS up/down counters, per-channel nonzero flags, registered tc/wrap strobes.
// Build option AWP_LOOPCNT_SAT_EN: counters saturate at 0 / all-ones instead of wrapping.
module awp_loopcnt import awp_pkg::*; #(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS
) (
  input  logic         clk_sys,
  input  logic         rab_n,
  awp_loopcnt_if.slave bus
);

  localparam int SELW = sel_width(CHANNELS);

  ch_op_e              op_dec;
  ch_op_e              ch_op  [CHANNELS];
  logic [WIDTH-1:0]    ch_val [CHANNELS];
  logic [CHANNELS-1:0] tc_ev, wrap_ev, nz;
  logic [WIDTH-1:0]    cnt;
  logic                tc_q, tc_d, wrap_q, wrap_d;

  // cda together with cua cancels out and falls through to hold.
  always_comb begin
    op_dec = OP_HOLD;
    if (bus.clr)                    op_dec = OP_CLR;
    else if (bus.load)              op_dec = OP_LOAD;
    else if (bus.cda && !bus.cua)   op_dec = OP_DEC;
    else if (bus.cua && !bus.cda)   op_dec = OP_INC;
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    assign ch_op[g] = (bus.sel == SELW'(g)) ? op_dec : OP_HOLD;

    awp_loopcnt_ch #(.WIDTH(WIDTH)) u_ch (
      .clk_i     (clk_sys),
      .rst_n_i   (rab_n),
      .op_i      (ch_op[g]),
      .in_i      (bus.in),
      .val_o     (ch_val[g]),
      .tc_ev_o   (tc_ev[g]),
      .wrap_ev_o (wrap_ev[g])
    );

    assign nz[g] = |ch_val[g];
  end

  // An out-of-range select matches no channel and reads as zero.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus.sel == SELW'(i)) cnt = ch_val[i];
    end
  end

  assign tc_d   = |tc_ev;
  assign wrap_d = |wrap_ev;

  always_ff @(posedge clk_sys or negedge rab_n) begin
    if (!rab_n) begin
      tc_q   <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      tc_q   <= tc_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.cnt  = cnt;
  assign bus.fic  = |cnt;
  assign bus.nz   = nz;
  assign bus.tc   = tc_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_awp_loopcnt.sv
// Bench for awp_loopcnt (WIDTH=6, CHANNELS=3): directed scenarios plus random traffic vs a value-level model.
module tb_awp_loopcnt;

  localparam int WIDTH    = 6;
  localparam int CHANNELS = 3;
  localparam int SELW     = 2;
  localparam int MAXV     = 63;
`ifdef AWP_LOOPCNT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk_sys = 1'b0;
  logic rab_n;

  awp_loopcnt_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SELW(SELW)) bus ();

  awp_loopcnt #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
    .clk_sys (clk_sys),
    .rab_n   (rab_n),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int checks   = 0;
  int failures = 0;
  int mdl [CHANNELS];
  bit exp_tc, exp_wrap;

  function automatic logic [WIDTH-1:0] exp_cnt(input int s);
    return (s < CHANNELS) ? WIDTH'(mdl[s]) : '0;
  endfunction

  function automatic logic [CHANNELS-1:0] exp_nz();
    logic [CHANNELS-1:0] r;
    for (int i = 0; i < CHANNELS; i++) r[i] = (mdl[i] != 0);
    return r;
  endfunction

  // Drive one cycle of strobes, advance the model, step past the edge.
  task automatic drive_edge(input int s, input bit ld, input bit cl,
                            input bit dn, input bit up, input int v);
    bus.sel  = SELW'(s);
    bus.load = ld;
    bus.clr  = cl;
    bus.cda  = dn;
    bus.cua  = up;
    bus.in   = WIDTH'(v);
    exp_tc   = 1'b0;
    exp_wrap = 1'b0;
    if (s < CHANNELS) begin
      if (cl) mdl[s] = 0;
      else if (ld) mdl[s] = v;
      else if (dn && !up) begin
        if (mdl[s] == 0) begin
          exp_wrap = 1'b1;
          mdl[s]   = SAT ? 0 : MAXV;
        end else begin
          exp_tc = (mdl[s] == 1);
          mdl[s] = mdl[s] - 1;
        end
      end else if (up && !dn) begin
        if (mdl[s] == MAXV) begin
          exp_wrap = 1'b1;
          mdl[s]   = SAT ? MAXV : 0;
        end else begin
          mdl[s] = mdl[s] + 1;
        end
      end
    end
    @(posedge clk_sys);
    #1;
  endtask

  task automatic peek(input int s);
    bus.load = 1'b0; bus.clr = 1'b0; bus.cda = 1'b0; bus.cua = 1'b0;
    bus.sel  = SELW'(s);
    #1;
  endtask

  task automatic test_reset();
    bus.sel = '0; bus.load = 0; bus.clr = 0; bus.cda = 0; bus.cua = 0; bus.in = '0;
    rab_n = 1'b1;
    #1 rab_n = 1'b0;
    #2;
    for (int i = 0; i < CHANNELS; i++) mdl[i] = 0;
    checks++; if (bus.cnt !== 6'd0) begin failures++; $display("FAIL reset_cnt got=%0d want=0", bus.cnt); end
    checks++; if (bus.nz !== 3'b000) begin failures++; $display("FAIL reset_nz got=%b want=000", bus.nz); end
    checks++; if (bus.tc !== 1'b0 || bus.wrap !== 1'b0) begin failures++; $display("FAIL reset_strobes tc=%b wrap=%b want 0/0", bus.tc, bus.wrap); end
    @(posedge clk_sys); #1 rab_n = 1'b1;

    drive_edge(0, 1, 0, 0, 0, 5);
    checks++; if (bus.cnt !== exp_cnt(0)) begin failures++; $display("FAIL load_before_reset got=%0d want=%0d", bus.cnt, exp_cnt(0)); end
    #3 rab_n = 1'b0;
    #1;
    for (int i = 0; i < CHANNELS; i++) mdl[i] = 0;
    checks++; if (bus.cnt !== 6'd0 || bus.nz !== 3'b000) begin failures++; $display("FAIL async_reset cnt=%0d nz=%b want 0/000", bus.cnt, bus.nz); end
    checks++; if (bus.tc !== 1'b0 || bus.wrap !== 1'b0) begin failures++; $display("FAIL async_reset_strobes tc=%b wrap=%b want 0/0", bus.tc, bus.wrap); end
    bus.load = 1'b0;
    @(posedge clk_sys); #1 rab_n = 1'b1;

    // A tc armed for the next edge must be lost when reset lands first.
    drive_edge(1, 1, 0, 0, 0, 1);
    bus.load = 1'b0; bus.cda = 1'b1;
    #3 rab_n = 1'b0;
    @(posedge clk_sys); #1;
    for (int i = 0; i < CHANNELS; i++) mdl[i] = 0;
    checks++; if (bus.tc !== 1'b0 || bus.cnt !== 6'd0) begin failures++; $display("FAIL reset_drops_tc tc=%b cnt=%0d want 0/0", bus.tc, bus.cnt); end
    bus.cda = 1'b0;
    @(posedge clk_sys); #1 rab_n = 1'b1;
  endtask

  task automatic test_loop();
    drive_edge(0, 1, 0, 0, 0, 17);
    drive_edge(1, 1, 0, 0, 0, 3);
    for (int k = 0; k < 3; k++) begin
      drive_edge(1, 0, 0, 1, 0, 0);
      checks++; if (bus.cnt !== exp_cnt(1) || bus.cnt !== WIDTH'(2 - k)) begin failures++; $display("FAIL loop_cnt step=%0d got=%0d want=%0d", k, bus.cnt, 2 - k); end
      checks++; if (bus.tc !== exp_tc) begin failures++; $display("FAIL loop_tc step=%0d got=%b want=%b", k, bus.tc, exp_tc); end
      checks++; if (bus.nz !== exp_nz()) begin failures++; $display("FAIL loop_nz step=%0d got=%b want=%b", k, bus.nz, exp_nz()); end
    end
    drive_edge(1, 0, 0, 0, 0, 0);
    checks++; if (bus.tc !== 1'b0) begin failures++; $display("FAIL loop_tc_one_cycle got=%b want=0", bus.tc); end
    peek(0);
    checks++; if (bus.cnt !== exp_cnt(0)) begin failures++; $display("FAIL loop_ch0_hold got=%0d want=%0d", bus.cnt, exp_cnt(0)); end
  endtask

  task automatic test_wrap();
    drive_edge(0, 0, 1, 0, 0, 0);
    drive_edge(0, 0, 0, 1, 0, 0);
    checks++; if (bus.cnt !== exp_cnt(0) || bus.wrap !== 1'b1) begin failures++; $display("FAIL wrap_dec cnt=%0d wrap=%b want=%0d/1", bus.cnt, bus.wrap, exp_cnt(0)); end
    checks++; if (bus.tc !== 1'b0) begin failures++; $display("FAIL wrap_dec_tc got=%b want=0", bus.tc); end
    drive_edge(0, 0, 0, 0, 1, 0);
    checks++; if (bus.cnt !== exp_cnt(0) || bus.wrap !== exp_wrap) begin failures++; $display("FAIL wrap_back_to_back cnt=%0d wrap=%b want=%0d/%b", bus.cnt, bus.wrap, exp_cnt(0), exp_wrap); end
    drive_edge(0, 0, 0, 0, 0, 0);
    checks++; if (bus.wrap !== 1'b0) begin failures++; $display("FAIL wrap_one_cycle got=%b want=0", bus.wrap); end
    drive_edge(0, 1, 0, 0, 0, MAXV);
    drive_edge(0, 0, 0, 0, 1, 0);
    checks++; if (bus.cnt !== exp_cnt(0) || bus.wrap !== 1'b1) begin failures++; $display("FAIL wrap_inc cnt=%0d wrap=%b want=%0d/1", bus.cnt, bus.wrap, exp_cnt(0)); end
  endtask

  task automatic test_priority();
    drive_edge(0, 1, 0, 0, 0, 10);
    drive_edge(0, 1, 1, 1, 0, 7);
    checks++; if (bus.cnt !== 6'd0) begin failures++; $display("FAIL prio_clr got=%0d want=0", bus.cnt); end
    drive_edge(0, 1, 0, 0, 0, 10);
    drive_edge(0, 1, 0, 1, 0, 7);
    checks++; if (bus.cnt !== 6'd7) begin failures++; $display("FAIL prio_load got=%0d want=7", bus.cnt); end
    drive_edge(0, 1, 0, 0, 0, 10);
    drive_edge(0, 0, 0, 1, 1, 0);
    checks++; if (bus.cnt !== 6'd10 || bus.tc !== 1'b0 || bus.wrap !== 1'b0) begin failures++; $display("FAIL prio_cancel cnt=%0d tc=%b wrap=%b want 10/0/0", bus.cnt, bus.tc, bus.wrap); end
    drive_edge(0, 1, 0, 0, 0, 1);
    drive_edge(0, 0, 0, 1, 1, 0);
    checks++; if (bus.cnt !== 6'd1 || bus.tc !== 1'b0) begin failures++; $display("FAIL prio_cancel_at1 cnt=%0d tc=%b want 1/0", bus.cnt, bus.tc); end
  endtask

  task automatic test_interleave();
    drive_edge(0, 1, 0, 0, 0, 2);
    drive_edge(1, 1, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      drive_edge(k % 2, 0, 0, 1, 0, 0);
      checks++; if (bus.cnt !== exp_cnt(k % 2) || bus.tc !== exp_tc || bus.wrap !== exp_wrap) begin
        failures++; $display("FAIL interleave step=%0d cnt=%0d tc=%b wrap=%b want=%0d/%b/%b", k, bus.cnt, bus.tc, bus.wrap, exp_cnt(k % 2), exp_tc, exp_wrap);
      end
    end
    for (int i = 0; i < 2; i++) begin
      peek(i);
      checks++; if (bus.cnt !== exp_cnt(i)) begin failures++; $display("FAIL interleave_final ch=%0d got=%0d want=%0d", i, bus.cnt, exp_cnt(i)); end
    end
  endtask

  task automatic test_out_of_range();
    for (int i = 0; i < CHANNELS; i++) drive_edge(i, 1, 0, 0, 0, int'($urandom_range(1, MAXV)));
    drive_edge(3, 1, 0, 0, 0, 9);
    checks++; if (bus.cnt !== 6'd0 || bus.fic !== 1'b0) begin failures++; $display("FAIL oor_read cnt=%0d fic=%b want 0/0", bus.cnt, bus.fic); end
    drive_edge(3, 0, 0, 1, 0, 0);
    checks++; if (bus.tc !== 1'b0 || bus.wrap !== 1'b0) begin failures++; $display("FAIL oor_strobes tc=%b wrap=%b want 0/0", bus.tc, bus.wrap); end
    for (int i = 0; i < CHANNELS; i++) begin
      peek(i);
      checks++; if (bus.cnt !== exp_cnt(i)) begin failures++; $display("FAIL oor_hold ch=%0d got=%0d want=%0d", i, bus.cnt, exp_cnt(i)); end
    end
  endtask

  task automatic test_random();
    int s, v, r;
    for (int n = 0; n < 400; n++) begin
      s = int'($urandom_range(0, 3));
      r = int'($urandom_range(0, 4));
      v = (r == 0) ? 0 : (r == 1) ? 1 : (r == 2) ? MAXV : int'($urandom_range(0, MAXV));
      drive_edge(s, ($urandom_range(0, 9) == 0), ($urandom_range(0, 14) == 0),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0), v);
      checks++;
      if (bus.cnt !== exp_cnt(s) || bus.fic !== (exp_cnt(s) != 0) || bus.nz !== exp_nz()
          || bus.tc !== exp_tc || bus.wrap !== exp_wrap) begin
        failures++;
        $display("FAIL random n=%0d sel=%0d cnt=%0d fic=%b nz=%b tc=%b wrap=%b want=%0d/%b/%b/%b/%b",
                 n, s, bus.cnt, bus.fic, bus.nz, bus.tc, bus.wrap,
                 exp_cnt(s), (exp_cnt(s) != 0), exp_nz(), exp_tc, exp_wrap);
      end
    end
  endtask

  initial begin
    test_reset();
    test_loop();
    test_wrap();
    test_priority();
    test_interleave();
    test_out_of_range();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
